rename_register_file: RTL and testbench

// - Architectural register file plus rename table (busy bit and ROB tag per register) for the Tomasulo core.
// - Sits between the decoder/dispatch stage and the ROB.
// - Generalises the 2-read, fixed-width register file:
//   - parameter-sized reads, registers, data width and tag width
//   - tag-checked commit, so an older commit never clears a younger rename
//   - hardwired x0
//   - same-cycle rename bypass

---
 rtl/rename_register_file.sv | 101 ++++++++++
 tb/tb_rename_register_file.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename state (busy bit + ROB tag) for the Tomasulo core.
// Optional macro RF_COMMIT_BYPASS_EN: lets a read port take a same-cycle matching commit value directly.
module rename_register_file #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int ROB_W  = 4,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    commit_en,
  input  logic [AW-1:0]           commit_rd,
  input  logic [ROB_W-1:0]        commit_tag,
  input  logic [XLEN-1:0]         commit_val,
  input  logic                    rename_en,
  input  logic [AW-1:0]           rename_rd,
  input  logic [ROB_W-1:0]        rename_tag,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic [NUM_RD*ROB_W-1:0] rd_tag,
  output logic [NUM_RD*XLEN-1:0]  rd_val,
  output logic [NUM_RD*ROB_W-1:0] rob_q_tag,
  input  logic [NUM_RD-1:0]       rob_q_ready,
  input  logic [NUM_RD*XLEN-1:0]  rob_q_val
);

  logic [XLEN-1:0]  regs [NREG];
  logic [ROB_W-1:0] tags [NREG];
  logic [NREG-1:0]  busy;

  logic             commit_wr;
  logic             commit_clr;
  logic             rename_wr;
  logic [AW-1:0]    a;

  // x0 is never written or renamed; a flush drops the same-cycle rename
  assign commit_wr  = commit_en && (commit_rd != '0);
  assign commit_clr = commit_wr && busy[commit_rd] && (tags[commit_rd] == commit_tag);
  assign rename_wr  = rename_en && (rename_rd != '0) && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else if (rdy) begin
      if (commit_wr)
        regs[commit_rd] <= commit_val;
      if (clear) begin
        busy <= '0;
      end else begin
        // A tag-mismatched commit leaves a younger rename busy; rename last so it wins.
        if (commit_clr)
          busy[commit_rd] <= 1'b0;
        if (rename_wr) begin
          busy[rename_rd] <= 1'b1;
          tags[rename_rd] <= rename_tag;
        end
      end
    end
  end

  always_comb begin
    rd_busy   = '0;
    rd_tag    = '0;
    rd_val    = '0;
    rob_q_tag = '0;
    a         = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = rd_addr[k*AW +: AW];
      if (a == '0) begin
        rd_busy[k] = 1'b0;
      end else if (rename_en && (rename_rd == a)) begin
        rd_busy[k]                 = 1'b1;
        rd_tag[k*ROB_W +: ROB_W]    = rename_tag;
        rob_q_tag[k*ROB_W +: ROB_W] = rename_tag;
`ifdef RF_COMMIT_BYPASS_EN
      end else if (commit_en && (commit_rd == a) && busy[a] && (tags[a] == commit_tag)) begin
        rd_tag[k*ROB_W +: ROB_W]    = tags[a];
        rob_q_tag[k*ROB_W +: ROB_W] = tags[a];
        rd_val[k*XLEN +: XLEN]      = commit_val;
`endif
      end else if (busy[a]) begin
        rd_tag[k*ROB_W +: ROB_W]    = tags[a];
        rob_q_tag[k*ROB_W +: ROB_W] = tags[a];
        if (rob_q_ready[k])
          rd_val[k*XLEN +: XLEN] = rob_q_val[k*XLEN +: XLEN];
        else
          rd_busy[k] = 1'b1;
      end else begin
        rd_val[k*XLEN +: XLEN] = regs[a];
      end
    end
  end

endmodule

// File: tb/tb_rename_register_file.sv
// Scoreboard bench for rename_register_file: expectations and sampled read-port outputs queued, then compared per task.
module tb_rename_register_file;

  localparam int XLEN = 32;
  localparam int ROB_W = 4;
  localparam int AW = 5;
  localparam int NUM_RD = 2;

  logic                    clk;
  logic                    rst;
  logic                    rdy;
  logic                    clear;
  logic                    commit_en;
  logic [AW-1:0]           commit_rd;
  logic [ROB_W-1:0]        commit_tag;
  logic [XLEN-1:0]         commit_val;
  logic                    rename_en;
  logic [AW-1:0]           rename_rd;
  logic [ROB_W-1:0]        rename_tag;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD-1:0]       rd_busy;
  logic [NUM_RD*ROB_W-1:0] rd_tag;
  logic [NUM_RD*XLEN-1:0]  rd_val;
  logic [NUM_RD*ROB_W-1:0] rob_q_tag;
  logic [NUM_RD-1:0]       rob_q_ready;
  logic [NUM_RD*XLEN-1:0]  rob_q_val;

  rename_register_file #(.XLEN(XLEN), .NREG(32), .ROB_W(ROB_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_val(commit_val),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_val(rd_val),
    .rob_q_tag(rob_q_tag), .rob_q_ready(rob_q_ready), .rob_q_val(rob_q_val)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [0:0]  port;
    logic        busy;
    logic [3:0]  tag;
    logic [31:0] val;
    logic [3:0]  rq;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; commit_en = 0; commit_rd = '0; commit_tag = '0; commit_val = '0;
    rename_en = 0; rename_rd = '0; rename_tag = '0; rob_q_ready = '0; rob_q_val = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Queue the expectation and capture what the DUT shows right now on that port
  task automatic expect_port(input int id, input int p, input logic busy, input logic [3:0] tag,
                             input logic [31:0] val, input logic [3:0] rq);
    ent_t e;
    ent_t o;
    e.id = id[7:0]; e.port = p[0:0]; e.busy = busy; e.tag = tag; e.val = val; e.rq = rq;
    o.id = id[7:0]; o.port = p[0:0];
    o.busy = rd_busy[p];
    o.tag  = rd_tag[p*ROB_W +: ROB_W];
    o.val  = rd_val[p*XLEN +: XLEN];
    o.rq   = rob_q_tag[p*ROB_W +: ROB_W];
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    ent_t e;
    ent_t o;
    rst = 1; rdy = 1; idle(); set_rd(5, 3);
    cycle();
    expect_port(1, 0, 0, 0, 0, 0);
    expect_port(2, 1, 0, 0, 0, 0);
    rst = 0;
    cycle();
    expect_port(3, 0, 0, 0, 0, 0);
    expect_port(4, 1, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.busy !== e.busy || (e.busy && o.tag !== e.tag) || (!e.busy && o.val !== e.val) || o.rq !== e.rq) begin
        n_errors++;
        $display("FAIL reset#%0d p%0d: got busy=%0b tag=%0d val=%h rq=%0d, want busy=%0b tag=%0d val=%h rq=%0d",
                 e.id, e.port, o.busy, o.tag, o.val, o.rq, e.busy, e.tag, e.val, e.rq);
      end
    end
  endtask

  task automatic test_rename_lookup();
    ent_t e;
    ent_t o;
    idle(); rename_en = 1; rename_rd = 5; rename_tag = 3; set_rd(5, 7);
    #1;
    expect_port(10, 0, 1, 3, 0, 3);
    expect_port(11, 1, 0, 0, 0, 0);
    cycle();
    idle();
    #1;
    expect_port(12, 0, 1, 3, 0, 3);
    rob_q_ready = 2'b01; rob_q_val = {32'h0, 32'hAB};
    #1;
    expect_port(13, 0, 0, 3, 32'hAB, 3);
    rename_en = 1; rename_rd = 7; rename_tag = 9; rob_q_ready = 2'b11;
    #1;
    expect_port(14, 1, 1, 9, 0, 9);
    idle();
    cycle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.busy !== e.busy || (e.busy && o.tag !== e.tag) || (!e.busy && o.val !== e.val) || o.rq !== e.rq) begin
        n_errors++;
        $display("FAIL lookup#%0d p%0d: got busy=%0b tag=%0d val=%h rq=%0d, want busy=%0b tag=%0d val=%h rq=%0d",
                 e.id, e.port, o.busy, o.tag, o.val, o.rq, e.busy, e.tag, e.val, e.rq);
      end
    end
  endtask

  task automatic test_tag_commit();
    ent_t e;
    ent_t o;
    idle(); set_rd(5, 8);
    rename_en = 1; rename_rd = 5; rename_tag = 3; cycle();
    rename_tag = 7; cycle();
    idle(); commit_en = 1; commit_rd = 5; commit_tag = 3; commit_val = 32'h11;
    #1;
    expect_port(20, 0, 1, 7, 0, 7);
    cycle();
    idle();
    #1;
    expect_port(21, 0, 1, 7, 0, 7);
    clear = 1; cycle();
    idle();
    #1;
    expect_port(22, 0, 0, 0, 32'h11, 0);
    rename_en = 1; rename_rd = 5; rename_tag = 7; cycle();
    idle(); commit_en = 1; commit_rd = 5; commit_tag = 7; commit_val = 32'h22;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    expect_port(23, 0, 0, 7, 32'h22, 7);
`else
    expect_port(23, 0, 1, 7, 0, 7);
`endif
    cycle();
    idle();
    #1;
    expect_port(24, 0, 0, 0, 32'h22, 0);
    commit_en = 1; commit_rd = 8; commit_tag = 0; commit_val = 32'h33;
    rename_en = 1; rename_rd = 8; rename_tag = 5;
    cycle();
    idle();
    #1;
    expect_port(25, 1, 1, 5, 0, 5);
    commit_en = 1; commit_rd = 8; commit_tag = 5; commit_val = 32'h44;
    cycle();
    idle();
    #1;
    expect_port(26, 1, 0, 0, 32'h44, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.busy !== e.busy || (e.busy && o.tag !== e.tag) || (!e.busy && o.val !== e.val) || o.rq !== e.rq) begin
        n_errors++;
        $display("FAIL commit#%0d p%0d: got busy=%0b tag=%0d val=%h rq=%0d, want busy=%0b tag=%0d val=%h rq=%0d",
                 e.id, e.port, o.busy, o.tag, o.val, o.rq, e.busy, e.tag, e.val, e.rq);
      end
    end
  endtask

  task automatic test_x0();
    ent_t e;
    ent_t o;
    idle(); set_rd(0, 0);
    rename_en = 1; rename_rd = 0; rename_tag = 2;
    #1;
    expect_port(30, 0, 0, 0, 0, 0);
    cycle();
    idle(); commit_en = 1; commit_rd = 0; commit_tag = 2; commit_val = 32'hFF;
    cycle();
    idle(); rob_q_ready = 2'b11; rob_q_val = {32'h5A5A, 32'hA5A5};
    #1;
    expect_port(31, 0, 0, 0, 0, 0);
    expect_port(32, 1, 0, 0, 0, 0);
    idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.busy !== e.busy || (e.busy && o.tag !== e.tag) || (!e.busy && o.val !== e.val) || o.rq !== e.rq) begin
        n_errors++;
        $display("FAIL x0#%0d p%0d: got busy=%0b tag=%0d val=%h rq=%0d, want busy=%0b tag=%0d val=%h rq=%0d",
                 e.id, e.port, o.busy, o.tag, o.val, o.rq, e.busy, e.tag, e.val, e.rq);
      end
    end
  endtask

  task automatic test_clear();
    ent_t e;
    ent_t o;
    idle();
    for (int r = 1; r <= 3; r++) begin
      rename_en = 1; rename_rd = r[AW-1:0]; rename_tag = r[ROB_W-1:0];
      cycle();
    end
    idle(); set_rd(1, 3);
    #1;
    expect_port(40, 0, 1, 1, 0, 1);
    expect_port(41, 1, 1, 3, 0, 3);
    clear = 1;
    commit_en = 1; commit_rd = 4; commit_tag = 0; commit_val = 32'h99;
    rename_en = 1; rename_rd = 6; rename_tag = 6;
    cycle();
    idle(); set_rd(1, 2);
    #1;
    expect_port(42, 0, 0, 0, 0, 0);
    expect_port(43, 1, 0, 0, 0, 0);
    set_rd(3, 4);
    #1;
    expect_port(44, 0, 0, 0, 0, 0);
    expect_port(45, 1, 0, 0, 32'h99, 0);
    set_rd(6, 5);
    #1;
    expect_port(46, 0, 0, 0, 0, 0);
    expect_port(47, 1, 0, 0, 32'h22, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.busy !== e.busy || (e.busy && o.tag !== e.tag) || (!e.busy && o.val !== e.val) || o.rq !== e.rq) begin
        n_errors++;
        $display("FAIL clear#%0d p%0d: got busy=%0b tag=%0d val=%h rq=%0d, want busy=%0b tag=%0d val=%h rq=%0d",
                 e.id, e.port, o.busy, o.tag, o.val, o.rq, e.busy, e.tag, e.val, e.rq);
      end
    end
  endtask

  task automatic test_rdy_hold();
    ent_t e;
    ent_t o;
    idle(); set_rd(9, 0); rdy = 0;
    rename_en = 1; rename_rd = 9; rename_tag = 4;
    commit_en = 1; commit_rd = 9; commit_tag = 0; commit_val = 32'h55;
    #1;
    expect_port(50, 0, 1, 4, 0, 4);
    cycle();
    idle();
    #1;
    expect_port(51, 0, 0, 0, 0, 0);
    rdy = 1; rename_en = 1; rename_rd = 9; rename_tag = 4;
    cycle();
    idle(); rdy = 0;
    commit_en = 1; commit_rd = 9; commit_tag = 4; commit_val = 32'h55;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    expect_port(52, 0, 0, 4, 32'h55, 4);
`else
    expect_port(52, 0, 1, 4, 0, 4);
`endif
    cycle();
    idle();
    #1;
    expect_port(53, 0, 1, 4, 0, 4);
    rdy = 1; commit_en = 1; commit_rd = 9; commit_tag = 4; commit_val = 32'h66;
    cycle();
    idle();
    #1;
    expect_port(54, 0, 0, 0, 32'h66, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.busy !== e.busy || (e.busy && o.tag !== e.tag) || (!e.busy && o.val !== e.val) || o.rq !== e.rq) begin
        n_errors++;
        $display("FAIL rdy#%0d p%0d: got busy=%0b tag=%0d val=%h rq=%0d, want busy=%0b tag=%0d val=%h rq=%0d",
                 e.id, e.port, o.busy, o.tag, o.val, o.rq, e.busy, e.tag, e.val, e.rq);
      end
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    ent_t o;
    idle(); rdy = 1;
    rename_en = 1; rename_rd = 10; rename_tag = 2;
    cycle();
    idle(); set_rd(4, 10);
    #1;
    expect_port(60, 0, 0, 0, 32'h99, 0);
    expect_port(61, 1, 1, 2, 0, 2);
    rdy = 0;
    #1;
    rst = 1;
    #1;
    expect_port(62, 0, 0, 0, 0, 0);
    expect_port(63, 1, 0, 0, 0, 0);
    cycle();
    expect_port(64, 0, 0, 0, 0, 0);
    expect_port(65, 1, 0, 0, 0, 0);
    rst = 0; rdy = 1;
    cycle();
    expect_port(66, 0, 0, 0, 0, 0);
    expect_port(67, 1, 0, 0, 0, 0);
    set_rd(9, 5);
    #1;
    expect_port(68, 0, 0, 0, 0, 0);
    expect_port(69, 1, 0, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.busy !== e.busy || (e.busy && o.tag !== e.tag) || (!e.busy && o.val !== e.val) || o.rq !== e.rq) begin
        n_errors++;
        $display("FAIL rstmid#%0d p%0d: got busy=%0b tag=%0d val=%h rq=%0d, want busy=%0b tag=%0d val=%h rq=%0d",
                 e.id, e.port, o.busy, o.tag, o.val, o.rq, e.busy, e.tag, e.val, e.rq);
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; rdy = 1; rd_addr = '0;
    idle();
    test_reset();
    test_rename_lookup();
    test_tag_commit();
    test_x0();
    test_clear();
    test_rdy_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
